// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator.
// One read or write per command, with a per-transfer ack timeout.
module wb_cmd_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_n;
  logic          we_n;
  logic [31:0]   adr_n;
  logic [31:0]   dat_n;
  logic [3:0]    sel_n;
  logic [31:0]   rdat_n;
  logic          err_n;

  // cyc/stb and the handshakes decode straight from state so an
  // asynchronous reset drops them without waiting for an edge.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign wb_cyc_o  = (state == BUS);
  assign wb_stb_o  = (state == BUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wb_we_o  <= we_n;
      wb_adr_o <= adr_n;
      wb_dat_o <= dat_n;
      wb_sel_o <= sel_n;
      rsp_dat  <= rdat_n;
      rsp_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = wb_we_o;
    adr_n   = wb_adr_o;
    dat_n   = wb_dat_o;
    sel_n   = wb_sel_o;
    rdat_n  = rsp_dat;
    err_n   = rsp_err;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n = BUS;
          cnt_n   = '0;
          we_n    = cmd_we;
          adr_n   = cmd_adr;
          dat_n   = cmd_we ? cmd_dat : '0;
          sel_n   = cmd_sel;
        end
      end
      BUS: begin
        // ack wins over a timeout landing on the same edge
        if (wb_ack_i) begin
          state_n = RESP;
          err_n   = 1'b0;
          rdat_n  = wb_we_o ? '0 : wb_dat_i;
        end else if (cnt == LAST) begin
          state_n = RESP;
          err_n   = 1'b1;
          rdat_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
          err_n   = 1'b0;
          rdat_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: directed table plus randomized
// transfers checked against a transaction-level model.
module tb_wb_cmd_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  wb_cmd_initiator #(.TIMEOUT(TO), .TW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] rdata;
    int          hold;
    bit          stray;
    bit          second;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Slave acks during stb cycle ack_at; beyond TO the timeout fires.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err = (v.ack_at > TO);
    r.exp_stb = r.exp_err ? TO : v.ack_at;
    r.exp_dat = (r.exp_err || v.we) ? 32'h0 : v.rdata;
    return r;
  endfunction

  task automatic run(input vec_t v);
    int  c;
    int  stb;
    bit  done;
    bit  bad;
    bit  bad2;
    logic [31:0] wd;
    wd = v.we ? v.dat : 32'h0;
    @(negedge clk);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_we = v.we;
    cmd_adr = v.adr;
    cmd_dat = v.dat;
    cmd_sel = v.sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we = ~v.we;
    cmd_adr = $urandom;
    cmd_dat = $urandom;
    cmd_sel = 4'($urandom);
    stb = 0;
    c = 1;
    done = 0;
    bad = 0;
    while (!done && c < 64) begin
      if (wb_cyc_o) begin
        stb++;
        if (wb_stb_o !== 1'b1 || wb_adr_o !== v.adr ||
            wb_we_o !== v.we || wb_sel_o !== v.sel ||
            wb_dat_o !== wd || cmd_ready !== 1'b0 ||
            rsp_valid !== 1'b0)
          bad = 1;
        wb_ack_i = (c == v.ack_at);
        wb_dat_i = (c == v.ack_at) ? v.rdata : $urandom;
        @(posedge clk);
        @(negedge clk);
        c++;
      end else begin
        done = 1;
      end
    end
    wb_ack_i = 1'b0;
    chk("bus_bound", {31'b0, done}, 1);
    chk("bus_stable", {31'b0, bad}, 0);
    chk("stb_cycles", stb, v.exp_stb);
    chk("rsp_valid", {31'b0, rsp_valid}, 1);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk("rsp_dat", rsp_dat, v.exp_dat);
    chk("cmd_ready_resp", {31'b0, cmd_ready}, 0);
    chk("adr_kept", wb_adr_o, v.adr);
    bad2 = 0;
    for (int i = 0; i < v.hold; i++) begin
      wb_ack_i = v.stray && (i == 0);
      wb_dat_i = $urandom;
      if (v.second) cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== v.exp_err ||
          rsp_dat !== v.exp_dat || wb_cyc_o !== 1'b0 ||
          cmd_ready !== 1'b0)
        bad2 = 1;
    end
    wb_ack_i = 1'b0;
    cmd_valid = 1'b0;
    if (v.hold > 0) chk("rsp_hold", {31'b0, bad2}, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'b0, rsp_valid}, 0);
    chk("err_clear", {31'b0, rsp_err}, 0);
    chk("cmd_ready_back", {31'b0, cmd_ready}, 1);
    chk("no_cyc_idle", {31'b0, wb_cyc_o}, 0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2,
               32'h0, 0, 0, 0, 1'b0, 32'h0, 2};
    tbl[1] = '{1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF, 4,
               32'h0012_3456, 0, 0, 0, 1'b0, 32'h0012_3456, 4};
    tbl[2] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, 99,
               32'h5555_AAAA, 3, 1, 0, 1'b1, 32'h0, 16};
    tbl[3] = '{1'b1, 32'h3000_000C, 32'hCAFE_F00D, 4'h3, 2,
               32'h0, 10, 0, 1, 1'b0, 32'h0, 2};
    tbl[4] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, 16,
               32'hA5A5_0001, 0, 0, 0, 1'b0, 32'hA5A5_0001, 16};
    tbl[5] = '{1'b0, 32'h3000_0014, 32'h0, 4'hF, 17,
               32'hA5A5_0002, 2, 1, 0, 1'b1, 32'h0, 16};
    tbl[6] = '{1'b0, 32'h3000_0018, 32'h0, 4'hC, 15,
               32'hA5A5_0003, 0, 0, 0, 1'b0, 32'hA5A5_0003, 15};
    tbl[7] = '{1'b0, 32'h3000_001C, 32'h0, 4'h1, 1,
               32'h7777_8888, 1, 0, 0, 1'b0, 32'h7777_8888, 1};

    #12;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
    chk("rst_stb", {31'b0, wb_stb_o}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_we", {31'b0, wb_we_o}, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat_o", wb_dat_o, 0);
    chk("rst_sel", {28'b0, wb_sel_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // stray ack while idle must not start anything
    @(negedge clk);
    wb_ack_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("idle_stray_cyc", {31'b0, wb_cyc_o}, 0);
    chk("idle_stray_rsp", {31'b0, rsp_valid}, 0);

    // reset in the middle of a bus cycle
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we = 1'b1;
    cmd_adr = 32'h3000_0020;
    cmd_dat = 32'h1234_5678;
    cmd_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_cyc", {31'b0, wb_cyc_o}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 0);
    chk("mid_rst_stb", {31'b0, wb_stb_o}, 0);
    chk("mid_rst_rsp", {31'b0, rsp_valid}, 0);
    chk("mid_rst_ready", {31'b0, cmd_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run(tbl[1]);

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom);
      v.adr = $urandom;
      v.dat = $urandom;
      v.sel = 4'($urandom);
      v.ack_at = $urandom_range(1, 20);
      v.rdata = $urandom;
      v.hold = $urandom_range(0, 3);
      v.stray = 1'($urandom);
      v.second = 1'($urandom);
      run(model(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
